// File: rtl/sprite_sram_pkg.sv
// rtl/sprite_sram_pkg.sv - shared widths, port indices and read-tag type for the sprite SRAM arbiter
package sprite_sram_pkg;

    // Default SRAM geometry for the sprite store
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 16;

    // Requester indices: display fetch owns the fixed-priority slot
    localparam logic PORT_DISP = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

    // Conflict counter ceiling
    localparam logic [15:0] CONFLICT_MAX = 16'hFFFF;

    // Tag remembering which port owns the read data arriving next cycle
    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

    // Build a tag for an access; writes never produce read data
    function automatic rd_tag_t make_tag(input logic en, input logic we, input logic port);
        rd_tag_t t;
        t.valid = en & ~we;
        t.port  = port;
        return t;
    endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// rtl/arb_wait_counter.sv - counts consecutive denied cycles of the loader port and raises starve
module arb_wait_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req1,
    input  logic gnt1,
    output logic starve
);

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    logic [7:0] wait_cnt;

    // Count while the loader is asking but not served; any grant or withdrawal restarts the streak
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 8'd0;
        end else if (!req1 || gnt1) begin
            wait_cnt <= 8'd0;
        end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Compare as "at or beyond" so the flag can never be skipped past
    assign starve = (wait_cnt >= MAX_W);

endmodule

// File: rtl/sprite_sram_arbiter.sv
// rtl/sprite_sram_arbiter.sv - two-port fixed-priority sprite SRAM arbiter, optional starvation guard via ARB_STARVE_GUARD_EN
module sprite_sram_arbiter
    import sprite_sram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic [15:0]           conflict_cnt
);

    logic    starve;
    rd_tag_t rd_tag;
    logic    sel_load;

`ifdef ARB_STARVE_GUARD_EN
    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk    (clk),
        .reset  (reset),
        .req1   (req1),
        .gnt1   (gnt1),
        .starve (starve)
    );
`else
    // Legal MAX_WAIT is 1..255, so the loader is never promoted in this build
    assign starve = (MAX_WAIT == 0);
`endif

    // Winner selection: display first unless the loader has waited too long; nothing granted in reset
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (req0 && !(req1 && starve)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    // SRAM mux: the loader drives the bus only when it holds the grant, otherwise the display values sit there
    always_comb begin
        sel_load   = gnt1;
        sram_en    = gnt0 | gnt1;
        sram_we    = we0;
        sram_addr  = addr0;
        sram_wdata = wdata0;
        if (sel_load == PORT_LOAD) begin
            sram_we    = we1;
            sram_addr  = addr1;
            sram_wdata = wdata1;
        end
    end

    // Remember the owner of each granted read for the following cycle's data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_tag <= '0;
        end else begin
            rd_tag <= make_tag(sram_en, sram_we, sel_load);
        end
    end

    // Saturating count of contended cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt <= 16'd0;
        end else if (req0 && req1 && (conflict_cnt != CONFLICT_MAX)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

    // Both ports see the SRAM output; only the tagged owner gets the valid strobe
    assign rdata0  = sram_rdata;
    assign rdata1  = sram_rdata;
    assign rvalid0 = rd_tag.valid && (rd_tag.port == PORT_DISP);
    assign rvalid1 = rd_tag.valid && (rd_tag.port == PORT_LOAD);

endmodule

// File: tb/tb_sprite_sram_arbiter.sv
// tb/tb_sprite_sram_arbiter.sv - self-checking bench for sprite_sram_arbiter
module tb_sprite_sram_arbiter;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int MW = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          sram_en, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic [15:0]   conflict_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sprite_sram_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_WAIT   (MW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req0         (req0),
        .req1         (req1),
        .we0          (we0),
        .we1          (we1),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .rvalid0      (rvalid0),
        .rvalid1      (rvalid1),
        .rdata0       (rdata0),
        .rdata1       (rdata1),
        .sram_en      (sram_en),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .conflict_cnt (conflict_cnt)
    );

    // Single-port synchronous write-first SRAM attached to the DUT
    logic [DW-1:0] sram_mem [0:65535];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                sram_mem[sram_addr] <= sram_wdata;
                sram_rdata          <= sram_wdata;
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    // Reference model state
    logic [DW-1:0] shadow [0:65535];
    int            m_conf;
    int            m_wait;
    bit            m_rv0, m_rv1;
    logic [DW-1:0] m_rd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic model_clear();
        m_conf = 0;
        m_wait = 0;
        m_rv0  = 1'b0;
        m_rv1  = 1'b0;
    endtask

    // Called at a falling edge with inputs already driven; checks the cycle, then advances one clock
    task automatic step();
        int            w;
        bit            starve_m;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          we;
        #1;
        starve_m = GUARD && (m_wait >= MW);
        if (req0 && !(req1 && starve_m)) w = 0;
        else if (req1)                   w = 1;
        else                             w = -1;
        check_eq("gnt0", gnt0, (w == 0));
        check_eq("gnt1", gnt1, (w == 1));
        check_eq("sram_en", sram_en, (w >= 0));
        a  = (w == 1) ? addr1  : addr0;
        d  = (w == 1) ? wdata1 : wdata0;
        we = (w == 1) ? we1    : we0;
        if (w >= 0) begin
            check_eq("sram_addr", sram_addr, a);
            check_eq("sram_we", sram_we, we);
            if (we) check_eq("sram_wdata", sram_wdata, d);
        end
        check_eq("rvalid0", rvalid0, m_rv0);
        check_eq("rvalid1", rvalid1, m_rv1);
        if (m_rv0) check_eq("rdata0", rdata0, m_rd);
        if (m_rv1) check_eq("rdata1", rdata1, m_rd);
        check_eq("conflict_cnt", conflict_cnt, m_conf);
        m_rv0 = 1'b0;
        m_rv1 = 1'b0;
        if (w >= 0) begin
            if (we) begin
                shadow[a] = d;
            end else begin
                m_rd = shadow[a];
                if (w == 0) m_rv0 = 1'b1;
                else        m_rv1 = 1'b1;
            end
        end
        if (req0 && req1 && m_conf < 65535) m_conf++;
        if (req1 && w != 1) m_wait++;
        else                m_wait = 0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge clk);
        #1;
        check_eq("rst_gnt0", gnt0, 0);
        check_eq("rst_gnt1", gnt1, 0);
        check_eq("rst_sram_en", sram_en, 0);
        check_eq("rst_rvalid0", rvalid0, 0);
        check_eq("rst_rvalid1", rvalid1, 0);
        check_eq("rst_conflict", conflict_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int            seen_g1;
        int            exp_g1;
        logic [DW-1:0] v;

        for (int i = 0; i < 65536; i++) begin
            v           = 8'($urandom);
            sram_mem[i] = v;
            shadow[i]   = v;
        end
        sram_mem[16'h0010] = 8'hAB;
        shadow[16'h0010]   = 8'hAB;
        sram_rdata = '0;
        model_clear();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        reset = 1'b1;
        @(negedge clk);
        do_reset();

        // Preloaded read on the display port
        drive(1, 0, 16'h0010, 8'h00, 0, 0, '0, '0);
        step();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        #1;
        check_eq("read_ab_rvalid0", rvalid0, 1);
        check_eq("read_ab_rdata0", rdata0, 8'hAB);
        check_eq("read_ab_rvalid1", rvalid1, 0);
        step();

        // Loader write, then display read of the same word
        drive(0, 0, '0, '0, 1, 1, 16'h0020, 8'h5A);
        step();
        drive(1, 0, 16'h0020, 8'h00, 0, 0, '0, '0);
        #1;
        check_eq("wr_no_rvalid0", rvalid0, 0);
        check_eq("wr_no_rvalid1", rvalid1, 0);
        step();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        #1;
        check_eq("wr_rd_rdata0", rdata0, 8'h5A);
        step();

        // Alternating single-port reads at 1..4
        for (int i = 1; i <= 4; i++) begin
            if (i % 2 == 1) drive(1, 0, 16'(i), '0, 0, 0, '0, '0);
            else            drive(0, 0, '0, '0, 1, 0, 16'(i), '0);
            step();
        end
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        step();

        // Ten contended cycles from a clean reset
        do_reset();
        seen_g1 = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 16'(i), '0, 1, 0, 16'(100 + i), '0);
            #1;
            if (gnt1) seen_g1++;
            step();
        end
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        #1;
        check_eq("conflict10", conflict_cnt, 10);
        check_eq("gnt1_in_10", seen_g1, GUARD ? 2 : 0);
        step();

        // Random traffic over a small address window
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom_range(0, 31)), 8'($urandom),
                  ($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom_range(0, 31)), 8'($urandom));
            step();
        end

        // Reset during a granted read discards the pending data
        drive(1, 1, 16'h0003, 8'h11, 1, 1, 16'h0004, 8'h22);
        step();
        drive(1, 0, 16'h0007, '0, 0, 0, '0, '0);
        #1;
        check_eq("midrd_gnt0", gnt0, 1);
        reset = 1'b1;
        #1;
        check_eq("midrd_rst_gnt0", gnt0, 0);
        check_eq("midrd_rst_en", sram_en, 0);
        @(negedge clk);
        #1;
        check_eq("midrd_rvalid0", rvalid0, 0);
        check_eq("midrd_rvalid1", rvalid1, 0);
        check_eq("midrd_conflict", conflict_cnt, 0);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        step();

        // Long contention: counter saturation and loader starvation behaviour
        do_reset();
        drive(1, 0, 16'h0001, '0, 1, 0, 16'h0002, '0);
        seen_g1 = 0;
        for (int i = 0; i < 65540; i++) begin
            #1;
            if (gnt1) seen_g1++;
            @(negedge clk);
        end
        exp_g1 = GUARD ? (65540 / (MW + 1)) : 0;
        #1;
        check_eq("conflict_sat", conflict_cnt, 16'hFFFF);
        check_eq("long_gnt1_count", seen_g1, exp_g1);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
